vga_frame_reader: RTL and testbench



---
 rtl/vga_pkg.sv | 44 ++++
 rtl/vga_frame_reader_if.sv | 10 +
 rtl/vga_timing.sv | 58 +++++
 rtl/vga_frame_reader.sv | 169 ++++++++++++++++
 tb/tb_vga_frame_reader.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, derived totals and common types for the frame reader.
package vga_pkg;

  // 640x480@60 default timing
  localparam int unsigned HActive = 640;
  localparam int unsigned HFp     = 16;
  localparam int unsigned HSync   = 96;
  localparam int unsigned HBp     = 48;
  localparam int unsigned VActive = 480;
  localparam int unsigned VFp     = 10;
  localparam int unsigned VSync   = 2;
  localparam int unsigned VBp     = 33;

  localparam int unsigned HTotal = HActive + HFp + HSync + HBp;  // 800
  localparam int unsigned VTotal = VActive + VFp + VSync + VBp;  // 525

  localparam int unsigned HSyncStart = HActive + HFp;            // 656
  localparam int unsigned HSyncEnd   = HSyncStart + HSync;       // 752
  localparam int unsigned VSyncStart = VActive + VFp;            // 490
  localparam int unsigned VSyncEnd   = VSyncStart + VSync;       // 492

  // Default centred image window and frame-buffer read latency
  localparam int unsigned ImgW      = 256;
  localparam int unsigned ImgH      = 256;
  localparam int unsigned ImgX0     = 192;
  localparam int unsigned ImgY0     = 112;
  localparam logic [7:0]  BgVal     = 8'h00;
  localparam int unsigned RdLatency = 1;

  // Screen coordinate, wide enough for 0..1023
  typedef logic [9:0] coord_t;

  // Control bits carried alongside each pixel through the read pipeline
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    logic win;
    logic fs;
  } vid_ctl_t;

  localparam vid_ctl_t CtlIdle = '{hs: 1'b1, vs: 1'b1, act: 1'b0, win: 1'b0, fs: 1'b0};

endpackage

// File: rtl/vga_frame_reader_if.sv
// Frame-buffer read port: the reader drives a byte address, the RAM returns grey data.
interface vga_frame_reader_if;

  logic [31:0] pixel_addr;
  logic [7:0]  pixel_val;

  modport master (output pixel_addr, input pixel_val);
  modport slave  (input pixel_addr, output pixel_val);

endinterface

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters and the raw (undelayed) sync, active and frame flags.
module vga_timing import vga_pkg::*; #(
  parameter int unsigned H_ACTIVE = HActive,
  parameter int unsigned H_FP     = HFp,
  parameter int unsigned H_SYNC   = HSync,
  parameter int unsigned H_BP     = HBp,
  parameter int unsigned V_ACTIVE = VActive,
  parameter int unsigned V_FP     = VFp,
  parameter int unsigned V_SYNC   = VSync,
  parameter int unsigned V_BP     = VBp
) (
  input  logic   clk,
  input  logic   reset,
  output coord_t o_h_cnt,
  output coord_t o_v_cnt,
  output logic   o_hs_raw,
  output logic   o_vs_raw,
  output logic   o_act_raw,
  output logic   o_fs_raw
);

  localparam coord_t HLast   = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t VLast   = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t HsStart = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HsEnd   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VsStart = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VsEnd   = coord_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam coord_t HAct    = coord_t'(H_ACTIVE);
  localparam coord_t VAct    = coord_t'(V_ACTIVE);

  coord_t r_h_cnt;
  coord_t r_v_cnt;

  // Raster counters; v advances when h wraps, both wrap together at the frame end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == HLast) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == VLast) ? '0 : r_v_cnt + 10'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 10'd1;
    end
  end

  // Raw timing flags decoded from the current counter state
  always_comb begin
    o_hs_raw  = !((r_h_cnt >= HsStart) && (r_h_cnt < HsEnd));
    o_vs_raw  = !((r_v_cnt >= VsStart) && (r_v_cnt < VsEnd));
    o_act_raw = (r_h_cnt < HAct) && (r_v_cnt < VAct);
    o_fs_raw  = (r_h_cnt == '0) && (r_v_cnt == '0);
  end

  assign o_h_cnt = r_h_cnt;
  assign o_v_cnt = r_v_cnt;

endmodule

// File: rtl/vga_frame_reader.sv
// Frame-buffer reader: window/address generation, control delay line and grey RGB outputs.
module vga_frame_reader import vga_pkg::*; #(
  parameter int unsigned H_ACTIVE   = HActive,
  parameter int unsigned H_FP       = HFp,
  parameter int unsigned H_SYNC     = HSync,
  parameter int unsigned H_BP       = HBp,
  parameter int unsigned V_ACTIVE   = VActive,
  parameter int unsigned V_FP       = VFp,
  parameter int unsigned V_SYNC     = VSync,
  parameter int unsigned V_BP       = VBp,
  parameter int unsigned IMG_W      = ImgW,
  parameter int unsigned IMG_H      = ImgH,
  parameter int unsigned IMG_X0     = ImgX0,
  parameter int unsigned IMG_Y0     = ImgY0,
  parameter logic [7:0]  BG_VAL     = BgVal,
  parameter int unsigned RD_LATENCY = RdLatency
) (
  input  logic                       clk,
  input  logic                       reset,
  vga_frame_reader_if.master         fb,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       blank_n,
  output logic                       sync_n,
  output logic [7:0]                 red,
  output logic [7:0]                 green,
  output logic [7:0]                 blue,
  output logic                       frame_start
);

  // Address register, RAM latency, then output register
  localparam int unsigned L    = RD_LATENCY + 2;
  // The output register is the last delay stage, so the line itself holds L-1 stages
  localparam int unsigned NDly = L - 1;

  localparam coord_t HLast    = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t VLast    = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t WinX0    = coord_t'(IMG_X0);
  localparam coord_t WinX1    = coord_t'(IMG_X0 + IMG_W);
  localparam coord_t WinY0    = coord_t'(IMG_Y0);
  localparam coord_t WinY1    = coord_t'(IMG_Y0 + IMG_H);
  localparam coord_t WinXLast = coord_t'(IMG_X0 + IMG_W - 1);

  if ((IMG_X0 + IMG_W > H_ACTIVE) || (IMG_Y0 + IMG_H > V_ACTIVE)) begin : g_bad_window
    $error("vga_frame_reader: image window does not fit inside the active area");
  end

  coord_t   w_h_cnt;
  coord_t   w_v_cnt;
  logic     w_hs_raw;
  logic     w_vs_raw;
  logic     w_act_raw;
  logic     w_fs_raw;
  logic     w_win_raw;
  vid_ctl_t w_ctl;
  vid_ctl_t w_ctl_last;

  logic [31:0] r_line_base;
  logic [31:0] r_col_off;
  logic [31:0] r_pixel_addr;
  vid_ctl_t    r_ctl_dly [NDly];
  logic        r_hsync;
  logic        r_vsync;
  logic        r_blank_n;
  logic        r_frame_start;
  logic [7:0]  r_grey;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk       (clk),
    .reset     (reset),
    .o_h_cnt   (w_h_cnt),
    .o_v_cnt   (w_v_cnt),
    .o_hs_raw  (w_hs_raw),
    .o_vs_raw  (w_vs_raw),
    .o_act_raw (w_act_raw),
    .o_fs_raw  (w_fs_raw)
  );

  // Image window decode and bundling of the raw control bits
  always_comb begin
    w_win_raw = w_act_raw &&
                (w_h_cnt >= WinX0) && (w_h_cnt < WinX1) &&
                (w_v_cnt >= WinY0) && (w_v_cnt < WinY1);
    w_ctl     = '{hs: w_hs_raw, vs: w_vs_raw, act: w_act_raw, win: w_win_raw, fs: w_fs_raw};
  end

  // Multiplier-free address: per-line base plus running column offset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_line_base  <= '0;
      r_col_off    <= '0;
      r_pixel_addr <= '0;
    end else begin
      r_pixel_addr <= w_win_raw ? (r_line_base + r_col_off) : '0;

      if (w_h_cnt == HLast) begin
        r_col_off <= '0;
      end else if (w_win_raw) begin
        r_col_off <= r_col_off + 32'd1;
      end

      // Cleared on the wrap into (0,0) so a window starting at line 0 still accumulates
      if ((w_h_cnt == HLast) && (w_v_cnt == VLast)) begin
        r_line_base <= '0;
      end else if (w_win_raw && (w_h_cnt == WinXLast)) begin
        r_line_base <= r_line_base + IMG_W;
      end
    end
  end

  // Control delay line matching the address-plus-RAM latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NDly; i++) begin
        r_ctl_dly[i] <= CtlIdle;
      end
    end else begin
      r_ctl_dly[0] <= w_ctl;
      for (int unsigned i = 1; i < NDly; i++) begin
        r_ctl_dly[i] <= r_ctl_dly[i-1];
      end
    end
  end

  assign w_ctl_last = r_ctl_dly[NDly-1];

  // Output register: final delay stage, samples RAM data in the same cycle it is valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_blank_n     <= 1'b0;
      r_frame_start <= 1'b0;
      r_grey        <= 8'h00;
    end else begin
      r_hsync       <= w_ctl_last.hs;
      r_vsync       <= w_ctl_last.vs;
      r_blank_n     <= w_ctl_last.act;
      r_frame_start <= w_ctl_last.fs;
      if (w_ctl_last.win) begin
        r_grey <= fb.pixel_val;
      end else if (w_ctl_last.act) begin
        r_grey <= BG_VAL;
      end else begin
        r_grey <= 8'h00;
      end
    end
  end

  assign fb.pixel_addr = r_pixel_addr;
  assign hsync         = r_hsync;
  assign vsync         = r_vsync;
  assign blank_n       = r_blank_n;
  assign sync_n        = 1'b0;
  assign frame_start   = r_frame_start;
  assign red           = r_grey;
  assign green         = r_grey;
  assign blue          = r_grey;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Self-checking bench for vga_frame_reader on a shrunken raster (28x15, 8x4 window at 6,3)
// so whole frames and a mid-frame reset fit in a short run.
module tb_vga_frame_reader;

  localparam int HA = 20, HF = 2, HS = 3, HB = 3, HT = 28;
  localparam int VA = 10, VF = 1, VS = 2, VB = 2, VT = 15;
  localparam int IW = 8, IH = 4, IX = 6, IY = 3;
  localparam int L  = 3;
  localparam logic [7:0] BG = 8'h40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hsync, vsync, blank_n, sync_n, frame_start;
  logic [7:0] red, green, blue;
  logic [7:0] r_ram;

  int n_checks = 0;
  int n_fail   = 0;

  // run statistics (first run only is checked)
  int hs_fall [2];
  int n_hs_fall;
  int hs_low_line0, blank_line0;
  int fs_t [3];
  int n_fs;
  int vs_low_frame0, vs_fall;

  vga_frame_reader_if fb();

  vga_frame_reader #(
    .H_ACTIVE   (HA),
    .H_FP       (HF),
    .H_SYNC     (HS),
    .H_BP       (HB),
    .V_ACTIVE   (VA),
    .V_FP       (VF),
    .V_SYNC     (VS),
    .V_BP       (VB),
    .IMG_W      (IW),
    .IMG_H      (IH),
    .IMG_X0     (IX),
    .IMG_Y0     (IY),
    .BG_VAL     (BG),
    .RD_LATENCY (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fb          (fb),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank_n     (blank_n),
    .sync_n      (sync_n),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // one-cycle synchronous RAM returning the low address byte
  always @(posedge clk) r_ram <= fb.pixel_addr[7:0];
  assign fb.pixel_val = r_ram;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit in_win(input int h, input int v);
    return (h >= IX) && (h < IX + IW) && (v >= IY) && (v < IY + IH);
  endfunction

  // t counts rising edges since reset release; outputs sampled 1 time unit after each edge
  task automatic run_check(input int n_cyc);
    int p, h, v, e_addr;
    logic e_hs, e_vs, e_act, e_fs;
    logic [7:0] e_grey;
    logic prev_hs, prev_vs;
    prev_hs = 1'b1;
    prev_vs = 1'b1;
    n_hs_fall = 0; hs_low_line0 = 0; blank_line0 = 0;
    n_fs = 0; vs_low_frame0 = 0; vs_fall = -1;
    for (int t = 1; t <= n_cyc; t++) begin
      @(posedge clk);
      #1;
      p = t - 1;
      h = p % HT;
      v = (p / HT) % VT;
      e_addr = in_win(h, v) ? ((v - IY) * IW + (h - IX)) : 0;
      if (t < L) begin
        e_hs = 1'b1; e_vs = 1'b1; e_act = 1'b0; e_fs = 1'b0; e_grey = 8'h00;
      end else begin
        p = t - L;
        h = p % HT;
        v = (p / HT) % VT;
        e_hs  = !((h >= HA + HF) && (h < HA + HF + HS));
        e_vs  = !((v >= VA + VF) && (v < VA + VF + VS));
        e_act = (h < HA) && (v < VA);
        e_fs  = (h == 0) && (v == 0);
        if (in_win(h, v)) e_grey = 8'((v - IY) * IW + (h - IX));
        else if (e_act)   e_grey = BG;
        else              e_grey = 8'h00;
      end
      check_eq("pixel_addr", fb.pixel_addr, e_addr);
      check_eq("hsync", hsync, e_hs);
      check_eq("vsync", vsync, e_vs);
      check_eq("blank_n", blank_n, e_act);
      check_eq("red", red, e_grey);
      check_eq("green", green, e_grey);
      check_eq("blue", blue, e_grey);
      check_eq("frame_start", frame_start, e_fs);
      check_eq("sync_n", sync_n, 0);

      // hand-computed points
      case (t)
        3:   check_eq("fs_first_at_L", frame_start, 1);
        24:  check_eq("blank_at_h21", blank_n, 0);
        25:  check_eq("hs_fall_h22", hsync, 0);
        60:  check_eq("bg_at_v2h1", red, 8'h40);
        92:  check_eq("addr_v3h7", fb.pixel_addr, 1);
        98:  check_eq("data_k5", red, 5);
        119: check_eq("addr_line_base", fb.pixel_addr, 8);
        182: check_eq("addr_last", fb.pixel_addr, 31);
        183: check_eq("addr_after_win", fb.pixel_addr, 0);
        default: ;
      endcase

      if (prev_hs && !hsync && n_hs_fall < 2) begin
        hs_fall[n_hs_fall] = t;
        n_hs_fall++;
      end
      if (t < L + HT && !hsync) hs_low_line0++;
      if (t < L + HT && blank_n) blank_line0++;
      if (frame_start && n_fs < 3) begin
        fs_t[n_fs] = t;
        n_fs++;
      end
      if (t >= L && t < L + HT * VT && !vsync) vs_low_frame0++;
      if (prev_vs && !vsync && vs_fall < 0) vs_fall = t;
      prev_hs = hsync;
      prev_vs = vsync;
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("rst_hsync", hsync, 1);
    check_eq("rst_vsync", vsync, 1);
    check_eq("rst_blank_n", blank_n, 0);
    check_eq("rst_red", red, 0);
    check_eq("rst_green", green, 0);
    check_eq("rst_blue", blue, 0);
    check_eq("rst_addr", fb.pixel_addr, 0);
    check_eq("rst_fs", frame_start, 0);
    check_eq("rst_sync_n", sync_n, 0);
    reset = 1'b0;

    // two frames plus 150 cycles: ends with the counters at line 5, column 10
    run_check(2 * HT * VT + 5 * HT + 10);

    check_eq("hs_fall_count", n_hs_fall, 2);
    check_eq("hs_fall_first", hs_fall[0], L + HA + HF);
    check_eq("hs_period", hs_fall[1] - hs_fall[0], HT);
    check_eq("hs_low_width", hs_low_line0, HS);
    check_eq("blank_n_width", blank_line0, HA);
    check_eq("fs_count", n_fs, 3);
    check_eq("fs_period", fs_t[1] - fs_t[0], HT * VT);
    check_eq("vs_low_cycles", vs_low_frame0, VS * HT);
    check_eq("vs_fall", vs_fall, L + (VA + VF) * HT);

    // mid-frame asynchronous reset inside the window
    check_eq("pre_rst_blank_n", blank_n, 1);
    #1;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_hsync", hsync, 1);
    check_eq("mid_rst_vsync", vsync, 1);
    check_eq("mid_rst_blank_n", blank_n, 0);
    check_eq("mid_rst_red", red, 0);
    check_eq("mid_rst_addr", fb.pixel_addr, 0);
    check_eq("mid_rst_fs", frame_start, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_check(HT * VT + 20);
    check_eq("restart_fs_count", n_fs, 2);
    check_eq("restart_fs_first", fs_t[0], L);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
